multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state sequencer that converts the single-cycle RISC-V datapath into a multicycle machine with shared, wait-stated memory. Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB. The controller drives every datapath enable and mux select and handshakes with a memory port that may stall. It counts retired instructions and traps on illegal opcodes or memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 16: the number of consecutive stalled memory cycles that causes a trap. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  when 1, the controller may start a new instruction fetch.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- funct3  in  3  IR[14:12].
- Zero  in  1  ALU result equals 0.
- Pos  in  1  ALU result is greater than 0.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  memory address select: 0 selects PC, 1 selects ALU result register.
- MemRead, MemWrite  out  1 each  memory direction.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  branch-taken PC load.
- PCSource  out  1  PC input select: 0 selects ALU (PC+4), 1 selects branch adder (OldPC + imm<<1).
- ALUSrcA  out  1  ALU A input: 0 selects PC, 1 selects register A.
- ALUSrcB  out  2  ALU B input: 0 selects register B, 1 selects constant 4, 2 selects imm.
- ALUOp  out  2  00 add, 01 branch subtract, 10 funct-decoded.
- MemtoReg  out  1  writeback select: 0 selects ALU result, 1 selects memory data.
- RegWrite  out  1  register file write.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- instret  out  32  retired-instruction count; wraps modulo 2^32.
- fault  out  2  0 none, 1 illegal opcode, 2 memory timeout.

## Operation
- Control outputs are combinational decodes of the state register, the latched opcode class and the latched funct3. The only exception is PCWriteCond, which also depends on Zero and Pos.
- FETCH:
  - While run=0, all outputs are 0 and the controller stays in FETCH.
  - While run=1, it drives mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00.
  - In the cycle where mem_ready=1, it also drives IRWrite=1 and PCWrite=1, then moves to DECODE.
- DECODE:
  - No outputs are asserted.
  - The controller latches the opcode class and funct3.
  - R-type=0110011, I-ALU=0010011, load=0000011, store=0100011, branch=1100011.
  - A valid class goes to EXEC. Any other opcode goes to TRAP with fault=1.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=0, ALUOp=10, then WB.
  - I-ALU: ALUSrcA=1, ALUSrcB=2, ALUOp=10, then WB.
  - Load and store: ALUSrcA=1, ALUSrcB=2, ALUOp=00, then MEM.
  - Branch: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSource=1, then FETCH.
  - Branch PCWriteCond = take. take is Zero for beq (000), !Zero for bne (001), !Zero&!Pos for blt (100), Zero|Pos for bge (101). Any other funct3 gives take=0.
- MEM:
  - Drives mem_req=1 and IorD=1, plus MemRead=1 for a load or MemWrite=1 for a store.
  - It holds these until mem_ready=1.
  - A load then goes to WB; a store goes to FETCH.
- WB: RegWrite=1. MemtoReg=1 for a load, 0 for R-type and I-ALU. Then FETCH.
- TRAP:
  - All control outputs are 0 and fault holds its value.
  - Only reset leaves TRAP.
- instret increments on every transition into FETCH from WB, from MEM (store) or from EXEC (branch), whether or not the branch is taken. It does not increment on entry to TRAP.
- Memory timeout:
  - A stall counter increments each cycle that mem_req=1 and mem_ready=0. It clears on completion or on a state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, the next state is TRAP with fault=2. No write strobe is completed in that case.

## Timing
- Reset (reset=0), asynchronous: state=FETCH, instret=0, fault=0, latched class and funct3 cleared.
  - While reset=0, all control outputs and mem_req are 0, including in FETCH with run=1.
  - Reset asserted mid-access drops mem_req immediately. Memory must tolerate an abandoned request.
- Handshake: a transfer completes at the rising edge where mem_req=1 and mem_ready=1 are both sampled. mem_ready may be high in the same cycle as the first request.
- Latency with zero wait states:
  - R-type and I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- run is sampled only in FETCH. Dropping run mid-instruction has no effect until the next FETCH.
- Under a zero-wait, back-to-back stream, instret increases by exactly one per completed instruction.

## Test plan
- Reset released with run=1, mem_ready=1, R-type add fetched: states 0→1→2→4→0. RegWrite=1 only in WB, instret=1 after 4 cycles.
- Load with mem_ready low for 3 cycles in MEM: MEM lasts 4 cycles with MemRead, IorD and mem_req held. WB has MemtoReg=1. The instruction takes 8 cycles total.
- beq with Zero=1, then bne with Zero=1: PCWriteCond=1 in EXEC of the first, 0 in EXEC of the second. Each instruction takes 3 cycles and instret advances by 2.
- opcode 0000000 in DECODE: state=7 and fault=1 on the next edge. All outputs stay 0 and instret is unchanged for 20 more cycles.
- MEM_TIMEOUT=4 with mem_ready held 0 during FETCH: state=7 and fault=2 after 4 stalled cycles. IRWrite and PCWrite are never asserted.
- reset pulsed low during MEM of a store: mem_req and MemWrite fall immediately, state=0, instret=0. After release with run=0, the controller idles in FETCH with mem_req=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// wait-stated shared memory port, retired-instruction counter and traps.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        Zero,
  input  logic        Pos,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic [1:0]  fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LD, C_ST, C_BR
  } cls_e;

  localparam logic [31:0] TO_M1 = MEM_TIMEOUT - 1;

  state_e      st_q, st_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ret_q, ret_d;
  logic [1:0]  flt_q, flt_d;
  logic        take, retire, stall;

  assign state   = st_q;
  assign instret = ret_q;
  assign fault   = flt_q;

  always_comb begin
    dec_cls = C_NONE;
    unique case (1'b1)
      opcode == 7'b0110011: dec_cls = C_R;
      opcode == 7'b0010011: dec_cls = C_I;
      opcode == 7'b0000011: dec_cls = C_LD;
      opcode == 7'b0100011: dec_cls = C_ST;
      opcode == 7'b1100011: dec_cls = C_BR;
      default:              dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (f3_q)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = !Zero && !Pos;
      3'b101:  take = Zero || Pos;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    st_d        = st_q;
    cls_d       = cls_q;
    f3_d        = f3_q;
    flt_d       = flt_q;
    retire      = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'b00;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    // Outputs stay quiet for as long as reset is held.
    if (reset) begin
      unique case (st_q)
        S_FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            if (mem_ready) begin
              IRWrite = 1'b1;
              PCWrite = 1'b1;
              st_d    = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          cls_d = dec_cls;
          f3_d  = funct3;
          if (dec_cls == C_NONE) begin
            st_d  = S_TRAP;
            flt_d = 2'd1;
          end else begin
            st_d = S_EXEC;
          end
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          unique case (cls_q)
            C_R: begin
              ALUOp = 2'b10;
              st_d  = S_WB;
            end
            C_I: begin
              ALUSrcB = 2'd2;
              ALUOp   = 2'b10;
              st_d    = S_WB;
            end
            C_LD, C_ST: begin
              ALUSrcB = 2'd2;
              st_d    = S_MEM;
            end
            C_BR: begin
              ALUOp       = 2'b01;
              PCSource    = 1'b1;
              PCWriteCond = take;
              st_d        = S_FETCH;
              retire      = 1'b1;
            end
            default: begin
              st_d  = S_TRAP;
              flt_d = 2'd1;
            end
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemRead  = (cls_q == C_LD);
          MemWrite = (cls_q == C_ST);
          if (mem_ready) begin
            st_d   = (cls_q == C_LD) ? S_WB : S_FETCH;
            retire = (cls_q != C_LD);
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls_q == C_LD);
          st_d     = S_FETCH;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
    stall = mem_req && !mem_ready;
    if (MEM_TIMEOUT != 0 && stall && cnt_q == TO_M1) begin
      st_d   = S_TRAP;
      flt_d  = 2'd2;
      retire = 1'b0;
    end
    if (st_d != st_q || (mem_req && mem_ready))
      cnt_d = '0;
    else if (stall)
      cnt_d = cnt_q + 32'd1;
    else
      cnt_d = cnt_q;
    ret_d = ret_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= S_FETCH;
      cls_q <= C_NONE;
      f3_q  <= '0;
      cnt_q <= '0;
      ret_q <= '0;
      flt_q <= '0;
    end else begin
      st_q  <= st_d;
      cls_q <= cls_d;
      f3_q  <= f3_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
      flt_q <= flt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a
// randomized instruction stream checked against a per-cycle phase model.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        Zero = 1'b0;
  logic        Pos = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic        PCWriteCond, PCSource, ALUSrcA, MemtoReg, RegWrite;
  logic [1:0]  ALUSrcB, ALUOp, fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR} kind_e;

  typedef struct packed {
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic       PCWriteCond, PCSource, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       MemtoReg, RegWrite;
  } ctl_t;

  typedef struct {
    logic [2:0] st;
    ctl_t       c;
    logic       rdy;
  } step_t;

  ctl_t got;
  assign got = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                MemtoReg, RegWrite};

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .funct3(funct3), .Zero(Zero), .Pos(Pos), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .state(state), .instret(instret), .fault(fault)
  );

  // Builds the expected cycle-by-cycle phases of one instruction from the
  // operand values, then drives and checks it; leaves time just after the
  // edge that returns to FETCH.
  task automatic run_instr(input kind_e k, input logic [2:0] f3,
                           input int a, input int b, input int wf,
                           input int wm, input string tag);
    step_t q[$];
    step_t s;
    ctl_t c;
    logic take;
    logic [6:0] op;
    op = 7'b0110011;
    case (k)
      K_R:  op = 7'b0110011;
      K_I:  op = 7'b0010011;
      K_LD: op = 7'b0000011;
      K_ST: op = 7'b0100011;
      K_BR: op = 7'b1100011;
      default: op = 7'b0110011;
    endcase
    case (f3)
      3'b000:  take = (a == b);
      3'b001:  take = (a != b);
      3'b100:  take = (a < b);
      3'b101:  take = (a >= b);
      default: take = 1'b0;
    endcase
    for (int i = 0; i <= wf; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      c.MemRead = 1'b1;
      c.ALUSrcB = 2'd1;
      c.IRWrite = (i == wf);
      c.PCWrite = (i == wf);
      s.st = 3'd0; s.c = c; s.rdy = (i == wf);
      q.push_back(s);
    end
    s.st = 3'd1; s.c = '0; s.rdy = 1'b0;
    q.push_back(s);
    c = '0;
    c.ALUSrcA = 1'b1;
    case (k)
      K_R: c.ALUOp = 2'b10;
      K_I: begin c.ALUSrcB = 2'd2; c.ALUOp = 2'b10; end
      K_LD, K_ST: c.ALUSrcB = 2'd2;
      default: begin
        c.ALUOp = 2'b01;
        c.PCSource = 1'b1;
        c.PCWriteCond = take;
      end
    endcase
    s.st = 3'd2; s.c = c; s.rdy = 1'b0;
    q.push_back(s);
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= wm; i++) begin
        c = '0;
        c.mem_req = 1'b1;
        c.IorD = 1'b1;
        c.MemRead = (k == K_LD);
        c.MemWrite = (k == K_ST);
        s.st = 3'd3; s.c = c; s.rdy = (i == wm);
        q.push_back(s);
      end
    end
    if (k == K_R || k == K_I || k == K_LD) begin
      c = '0;
      c.RegWrite = 1'b1;
      c.MemtoReg = (k == K_LD);
      s.st = 3'd4; s.c = c; s.rdy = 1'b0;
      q.push_back(s);
    end
    exp_ret++;
    opcode = op;
    funct3 = f3;
    Zero = (a == b);
    Pos = (a > b);
    run = 1'b1;
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      #1;
      if (state !== q[i].st) begin
        fails++;
        $display("FAIL %s step%0d state got=%0d exp=%0d",
                 tag, i, state, q[i].st);
      end
      tests++;
      if (got !== q[i].c) begin
        fails++;
        $display("FAIL %s step%0d ctl got=%h exp=%h",
                 tag, i, got, q[i].c);
      end
      tests++;
    end
    @(posedge clk);
    #1;
    if (state !== 3'd0 || instret !== 32'(exp_ret)) begin
      fails++;
      $display("FAIL %s retire state=%0d instret=%0d exp state=0 instret=%0d",
               tag, state, instret, exp_ret);
    end
    tests++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (got !== '0 || state !== 3'd0 || instret !== 32'd0 ||
          fault !== 2'd0) begin
        fails++;
        $display("FAIL reset ctl=%h state=%0d instret=%0d fault=%0d exp all 0",
                 got, state, instret, fault);
      end
      tests++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_rtype();
    run_instr(K_R, 3'b000, 3, 4, 0, 0, "rtype_add");
    if (instret !== 32'd1) begin
      fails++;
      $display("FAIL rtype_instret got=%0d exp=1", instret);
    end
    tests++;
  endtask

  task automatic test_load_wait();
    run_instr(K_LD, 3'b010, 0, 0, 0, 3, "load_wait3");
  endtask

  task automatic test_branch();
    logic [31:0] base;
    base = instret;
    run_instr(K_BR, 3'b000, 7, 7, 0, 0, "beq_taken");
    run_instr(K_BR, 3'b001, 7, 7, 0, 0, "bne_not_taken");
    if (instret - base !== 32'd2) begin
      fails++;
      $display("FAIL branch_instret delta got=%0d exp=2", instret - base);
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    kind_e k;
    base = instret;
    for (int n = 0; n < 12; n++) begin
      k = kind_e'(int'($urandom_range(0, 4)));
      run_instr(k, 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 4)) - 2,
                int'($urandom_range(0, 4)) - 2, 0, 0, "b2b");
    end
    if (instret - base !== 32'd12) begin
      fails++;
      $display("FAIL b2b_instret delta got=%0d exp=12", instret - base);
    end
    tests++;
  endtask

  task automatic test_random();
    kind_e k;
    for (int n = 0; n < 40; n++) begin
      k = kind_e'(int'($urandom_range(0, 4)));
      run_instr(k, 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 6)) - 3,
                int'($urandom_range(0, 6)) - 3,
                int'($urandom_range(0, TO - 1)),
                int'($urandom_range(0, TO - 1)), "random");
    end
  endtask

  task automatic test_reset_mid_store();
    run = 1'b1;
    opcode = 7'b0100011;
    funct3 = 3'b010;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    if (state !== 3'd3 || mem_req !== 1'b1 || MemWrite !== 1'b1) begin
      fails++;
      $display("FAIL store_mem state=%0d mem_req=%0d MemWrite=%0d exp 3/1/1",
               state, mem_req, MemWrite);
    end
    tests++;
    reset = 1'b0;
    #1;
    if (mem_req !== 1'b0 || MemWrite !== 1'b0 || state !== 3'd0 ||
        instret !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset mem_req=%0d MemWrite=%0d state=%0d instret=%0d exp 0",
               mem_req, MemWrite, state, instret);
    end
    tests++;
    run = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_ret = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (state !== 3'd0 || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL idle state=%0d mem_req=%0d exp 0/0", state, mem_req);
      end
      tests++;
    end
  endtask

  task automatic test_illegal();
    run = 1'b1;
    opcode = 7'b0000000;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    if (state !== 3'd0 || IRWrite !== 1'b1) begin
      fails++;
      $display("FAIL illegal_fetch state=%0d IRWrite=%0d exp 0/1",
               state, IRWrite);
    end
    tests++;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    if (state !== 3'd1 || got !== '0) begin
      fails++;
      $display("FAIL illegal_decode state=%0d ctl=%h exp 1/0", state, got);
    end
    tests++;
    @(posedge clk);
    #1;
    if (state !== 3'd7 || fault !== 2'd1) begin
      fails++;
      $display("FAIL illegal_trap state=%0d fault=%0d exp 7/1", state, fault);
    end
    tests++;
    repeat (20) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (state !== 3'd7 || got !== '0 || fault !== 2'd1 ||
          instret !== 32'(exp_ret)) begin
        fails++;
        $display("FAIL trap_hold state=%0d ctl=%h fault=%0d instret=%0d exp 7/0/1/%0d",
                 state, got, fault, instret, exp_ret);
      end
      tests++;
    end
  endtask

  task automatic test_timeout();
    logic strobe;
    strobe = 1'b0;
    run = 1'b1;
    mem_ready = 1'b0;
    opcode = 7'b0110011;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      #1;
      strobe = strobe | IRWrite | PCWrite;
      if (state !== 3'd0 || mem_req !== 1'b1) begin
        fails++;
        $display("FAIL timeout_stall%0d state=%0d mem_req=%0d exp 0/1",
                 i, state, mem_req);
      end
      tests++;
    end
    @(negedge clk);
    #1;
    strobe = strobe | IRWrite | PCWrite;
    if (state !== 3'd7 || fault !== 2'd2 || got !== '0) begin
      fails++;
      $display("FAIL timeout_trap state=%0d fault=%0d ctl=%h exp 7/2/0",
               state, fault, got);
    end
    tests++;
    if (strobe !== 1'b0 || instret !== 32'(exp_ret)) begin
      fails++;
      $display("FAIL timeout_strobe strobe=%0d instret=%0d exp 0/%0d",
               strobe, instret, exp_ret);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_store();
    test_illegal();
    do_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
